sfx_sequencer: RTL and testbench

- Sits directly upstream of the audio codec interface in the Pac-Man audio path.
- Accepts one-cycle game sound events (start, chomp, eatghost, death) and arbitrates between them by priority.
- Walks the matching clip region of the synchronous 8-bit music ROM at a fixed sample rate.
- Presents each sample as 24-bit signed PCM to the codec write port using the write/write_ready handshake.

---
 rtl/sfx_sequencer_if.sv | 27 ++
 rtl/sfx_sequencer.sv | 172 +++++++++++++++++
 tb/tb_sfx_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/sfx_sequencer_if.sv
// Codec-side and ROM-side signal bundle for the Pac-Man sound-effect sequencer.
// master = sequencer, slave = ROM/codec side.
interface sfx_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0]  rom_addr;
  logic [7:0]         rom_q;
  logic               write_ready;
  logic               write;
  logic signed [23:0] sample_out;

  modport master (
    output rom_addr,
    input  rom_q,
    input  write_ready,
    output write,
    output sample_out
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    output write_ready,
    input  write,
    input  sample_out
  );
endinterface

// File: rtl/sfx_sequencer.sv
// Priority-arbitrated sound-effect player: walks ROM clips at the sample rate and
// feeds 24-bit PCM to the codec. Optional volume scaling via macro SFX_VOLUME_EN.
module sfx_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int CLK_DIV    = 6250,
  parameter int START_BASE = 0,
  parameter int START_LEN  = 16384,
  parameter int CHOMP_BASE = 16384,
  parameter int CHOMP_LEN  = 2048,
  parameter int GHOST_BASE = 18432,
  parameter int GHOST_LEN  = 4096,
  parameter int DEATH_BASE = 22528,
  parameter int DEATH_LEN  = 12288
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       chomp,
  input  logic       eatghost,
  input  logic       death,
`ifdef SFX_VOLUME_EN
  input  logic [1:0] vol,
`endif
  sfx_sequencer_if.master bus,
  output logic       busy,
  output logic [1:0] clip_id,
  output logic       overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_div;
  logic [1:0]          r_clip;
  logic [ADDR_W-1:0]   r_base, r_len_m1, r_idx;
  logic                r_fetch_vld_p0;
  logic signed [23:0]  r_sample_p1;
  logic                r_vld_p1;
  logic                r_overrun;

  logic                w_tick, w_ev_any, w_accept, w_fetch, w_capture, w_last;
  logic                w_load_zero, w_load, w_write;
  logic [1:0]          w_ev_id;
  logic [ADDR_W-1:0]   w_new_base, w_new_len_m1;
  logic signed [23:0]  w_load_val;

  // Clip order by importance, independent of the clip_id encoding.
  function automatic logic [1:0] f_rank(input logic [1:0] id);
    case (id)
      2'd3:    f_rank = 2'd3;
      2'd0:    f_rank = 2'd2;
      2'd2:    f_rank = 2'd1;
      default: f_rank = 2'd0;
    endcase
  endfunction

  function automatic logic signed [23:0] f_to_pcm(input logic [7:0] q);
    f_to_pcm = {q ^ 8'h80, 16'h0000};
  endfunction

`ifdef SFX_VOLUME_EN
  function automatic logic signed [23:0] f_scale(input logic signed [23:0] s,
                                                 input logic [1:0] v);
    f_scale = s >>> v;
  endfunction
`endif

  assign w_tick   = (r_div == DIV_LAST);
  assign w_ev_any = start | chomp | eatghost | death;

  always_comb begin
    w_ev_id      = 2'd1;
    w_new_base   = ADDR_W'(CHOMP_BASE);
    w_new_len_m1 = ADDR_W'(CHOMP_LEN - 1);
    if (death)         w_ev_id = 2'd3;
    else if (start)    w_ev_id = 2'd0;
    else if (eatghost) w_ev_id = 2'd2;
    case (w_ev_id)
      2'd0: begin w_new_base = ADDR_W'(START_BASE); w_new_len_m1 = ADDR_W'(START_LEN - 1); end
      2'd2: begin w_new_base = ADDR_W'(GHOST_BASE); w_new_len_m1 = ADDR_W'(GHOST_LEN - 1); end
      2'd3: begin w_new_base = ADDR_W'(DEATH_BASE); w_new_len_m1 = ADDR_W'(DEATH_LEN - 1); end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fetch     = 1'b0;
    w_capture   = 1'b0;
    w_last      = 1'b0;
    w_load_zero = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept    = w_ev_any;
        w_load_zero = w_tick && !w_ev_any;
        if (w_ev_any) w_state_nxt = S_PLAY;
      end
      S_PLAY: begin
        // An accepted event drops any fetch still in flight for the old clip.
        w_accept  = w_ev_any && (f_rank(w_ev_id) >= f_rank(r_clip));
        w_fetch   = w_tick && !w_accept;
        w_capture = r_fetch_vld_p0 && !w_accept;
        w_last    = w_capture && (r_idx == r_len_m1);
        if (w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: divider, clip position and ROM fetch issue
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_div          <= '0;
      r_clip         <= '0;
      r_base         <= '0;
      r_len_m1       <= '0;
      r_idx          <= '0;
      r_fetch_vld_p0 <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_fetch_vld_p0 <= w_fetch;
      if (w_accept)    r_div <= DIV_LAST;
      else if (w_tick) r_div <= '0;
      else             r_div <= r_div + 1'b1;
      if (w_accept) begin
        r_clip   <= w_ev_id;
        r_base   <= w_new_base;
        r_len_m1 <= w_new_len_m1;
        r_idx    <= '0;
      end else if (w_capture) begin
        r_idx <= r_idx + 1'b1;
        if (w_last) r_clip <= 2'd0;
      end
    end
  end

`ifdef SFX_VOLUME_EN
  assign w_load_val = w_capture ? f_scale(f_to_pcm(bus.rom_q), vol) : '0;
`else
  assign w_load_val = w_capture ? f_to_pcm(bus.rom_q) : '0;
`endif
  assign w_load  = w_capture | w_load_zero;
  assign w_write = r_vld_p1 & bus.write_ready;

  // Stage p1: sample register toward the codec
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sample_p1 <= '0;
      r_vld_p1    <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_load) begin
      r_sample_p1 <= w_load_val;
      r_vld_p1    <= 1'b1;
      if (r_vld_p1 && !w_write) r_overrun <= 1'b1;
    end else if (w_write) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign bus.rom_addr   = r_base + r_idx;
  assign bus.write      = w_write;
  assign bus.sample_out = r_sample_p1;
  assign busy           = (r_state == S_PLAY);
  assign clip_id        = r_clip;
  assign overrun        = r_overrun;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Randomized and directed bench for sfx_sequencer against a clip-level reference model.
module tb_sfx_sequencer;
  localparam int CLK_DIV    = 6;
  localparam int START_BASE = 0,     START_LEN = 64;
  localparam int CHOMP_BASE = 16384, CHOMP_LEN = 2048;
  localparam int GHOST_BASE = 18432, GHOST_LEN = 32;
  localparam int DEATH_BASE = 22528, DEATH_LEN = 96;

  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1, start = 1'b0, chomp = 1'b0, eatghost = 1'b0, death = 1'b0;
  logic busy, overrun;
  logic [1:0] clip_id;
`ifdef SFX_VOLUME_EN
  logic [1:0] vol = 2'd0;
`endif
  bit force_ff = 1'b0;

  sfx_sequencer_if #(.ADDR_W(16)) bus();

  sfx_sequencer #(
    .ADDR_W(16), .CLK_DIV(CLK_DIV),
    .START_BASE(START_BASE), .START_LEN(START_LEN),
    .CHOMP_BASE(CHOMP_BASE), .CHOMP_LEN(CHOMP_LEN),
    .GHOST_BASE(GHOST_BASE), .GHOST_LEN(GHOST_LEN),
    .DEATH_BASE(DEATH_BASE), .DEATH_LEN(DEATH_LEN)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .start(start), .chomp(chomp), .eatghost(eatghost), .death(death),
`ifdef SFX_VOLUME_EN
    .vol(vol),
`endif
    .bus(bus), .busy(busy), .clip_id(clip_id), .overrun(overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] rom_fn(input logic [15:0] a);
    return 8'(a[7:0] * 8'd29) ^ a[15:8];
  endfunction

  always @(posedge CLOCK_50) bus.rom_q <= force_ff ? 8'hFF : rom_fn(bus.rom_addr);

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: clip table, playback position and pending ROM words.
  int clip_base[4] = '{START_BASE, CHOMP_BASE, GHOST_BASE, DEATH_BASE};
  int clip_len[4]  = '{START_LEN, CHOMP_LEN, GHOST_LEN, DEATH_LEN};
  int prio[4]      = '{2, 0, 1, 3};
  int prio_order[4] = '{3, 0, 2, 1};
  bit m_known = 0, m_busy = 0, m_valid = 0, m_ovr = 0;
  int m_clip = 0, m_idx = 0, m_div = 0;
  logic signed [23:0] m_sample = '0;
  logic [7:0] m_fetch_q[$];
  bit obs_write;
  logic signed [23:0] obs_sample;

  task automatic model_step(input logic [3:0] ev, input bit wr, input bit rst);
    bit tick, xfer, accept, load, was_busy;
    int sel;
    logic signed [23:0] lv;
    if (rst) begin
      m_known = 1; m_busy = 0; m_valid = 0; m_ovr = 0;
      m_clip = 0; m_idx = 0; m_div = 0; m_sample = '0;
      m_fetch_q.delete();
      return;
    end
    tick = (m_div == CLK_DIV - 1);
    xfer = m_valid && wr;
    was_busy = m_busy;
    sel = -1;
    for (int k = 0; k < 4; k++)
      if (sel < 0 && ev[prio_order[k] == 0 ? 0 : prio_order[k] == 1 ? 1 : prio_order[k] == 2 ? 2 : 3])
        sel = prio_order[k];
    accept = (sel >= 0) && (!m_busy || prio[sel] >= prio[m_clip]);
    load = 0; lv = '0;
    if (accept) begin
      m_fetch_q.delete();
      m_busy = 1; m_clip = sel; m_idx = 0; m_div = CLK_DIV - 1;
    end else begin
      if (m_fetch_q.size() > 0) begin
        lv = {m_fetch_q.pop_front() ^ 8'h80, 16'h0};
`ifdef SFX_VOLUME_EN
        lv = lv >>> vol;
`endif
        load = 1;
        if (m_idx == clip_len[m_clip] - 1) begin m_busy = 0; m_clip = 0; end
        m_idx++;
      end
      if (tick) begin
        if (was_busy)
          m_fetch_q.push_back(force_ff ? 8'hFF : rom_fn(16'(clip_base[m_clip] + m_idx)));
        else begin
          load = 1; lv = '0;
        end
      end
      m_div = tick ? 0 : m_div + 1;
    end
    if (load) begin
      if (m_valid && !xfer) m_ovr = 1;
      m_sample = lv; m_valid = 1;
    end else if (xfer) m_valid = 0;
  endtask

  // ev bits: [0] start, [1] chomp, [2] eatghost, [3] death
  task automatic cyc(input logic [3:0] ev, input bit wr, input bit rst);
    @(negedge CLOCK_50);
    reset = rst; start = ev[0]; chomp = ev[1]; eatghost = ev[2]; death = ev[3];
    bus.write_ready = wr;
    #1;
    obs_write = bus.write; obs_sample = bus.sample_out;
    if (m_known) begin
      chk("busy", busy, m_busy);
      chk("clip_id", clip_id, m_clip);
      chk("overrun", overrun, m_ovr);
      chk("sample", bus.sample_out, m_sample);
      chk("write", bus.write, m_valid && wr);
      if (m_busy) chk("rom_addr", bus.rom_addr, clip_base[m_clip] + m_idx);
    end
    model_step(ev, wr, rst);
    @(posedge CLOCK_50);
    #1;
  endtask

  int n_wr;
  logic signed [23:0] exp_new;

  initial begin
    bus.write_ready = 1'b1;
    repeat (3) cyc(4'b0, 1, 1);
    chk("rst_busy", busy, 0);
    chk("rst_clip", clip_id, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_write", bus.write, 0);
    chk("rst_sample", bus.sample_out, 0);
    chk("rst_addr", bus.rom_addr, 0);

    // idle silence: first write after the first full divider period
    n_wr = 0;
    for (int i = 0; i < 6 * CLK_DIV; i++) begin
      cyc(4'b0, 1, 0);
      if (obs_write) n_wr++;
    end
    chk("idle_writes", n_wr, 5);

    force_ff = 1;
    cyc(4'b0010, 1, 0);
    chk("chomp_addr", bus.rom_addr, 16384);
    chk("chomp_busy", busy, 1);
    chk("chomp_id", clip_id, 1);
    cyc(4'b0, 1, 0);
    cyc(4'b0, 1, 0);
    chk("chomp_first", bus.sample_out, 24'h7F0000);
    for (int i = 0; i < CHOMP_LEN * CLK_DIV + 60 && busy; i++) cyc(4'b0, 1, 0);
    chk("chomp_done", busy, 0);
    force_ff = 0;
    repeat (CLK_DIV + 3) cyc(4'b0, 1, 0);
    chk("silence", bus.sample_out, 0);

    cyc(4'b0010, 1, 0);
    repeat (20) cyc(4'b0, 1, 0);
    cyc(4'b1000, 1, 0);
    chk("pre_death_addr", bus.rom_addr, 22528);
    chk("pre_death_id", clip_id, 3);
    repeat (20) cyc(4'b0, 1, 0);
    cyc(4'b0100, 1, 0);
    chk("ghost_ignored", clip_id, 3);
    repeat (15) cyc(4'b0, 1, 0);
    cyc(4'b1000, 1, 0);
    chk("death_restart", bus.rom_addr, 22528);

    cyc(4'b0, 1, 1);
    cyc(4'b0011, 1, 0);
    chk("same_cyc_id", clip_id, 0);
    chk("same_cyc_busy", busy, 1);
    chk("same_cyc_addr", bus.rom_addr, 0);

    repeat (2 * CLK_DIV + 3) cyc(4'b0, 0, 0);
    chk("ovr_set", overrun, 1);
    exp_new = m_sample;
    cyc(4'b0, 1, 0);
    chk("ovr_write", obs_write, 1);
    chk("ovr_newest", obs_sample, exp_new);
    repeat (4) cyc(4'b0, 1, 0);
    chk("ovr_sticky", overrun, 1);

    cyc(4'b1000, 1, 0);
    repeat (30) cyc(4'b0, 1, 0);
    cyc(4'b0, 1, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_write", bus.write, 0);
    chk("mid_rst_ovr", overrun, 0);
    chk("mid_rst_addr", bus.rom_addr, 0);

    for (int i = 0; i < 15000; i++) begin
      logic [3:0] ev;
      bit wr, rs;
      ev = 4'b0;
      if ($urandom_range(0, 99) == 0) ev = 4'($urandom_range(1, 15));
      wr = ($urandom_range(0, 7) != 0);
      rs = ($urandom_range(0, 2999) == 0);
`ifdef SFX_VOLUME_EN
      vol = 2'($urandom_range(0, 3));
`endif
      cyc(ev, wr, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
